// File: rtl/axi_addr_ch_rxs.sv
// axi_addr_ch_rxs
//   Address-channel receiver sitting ahead of the translation logic and
//   axi_addr_ch_txs. AR/AW beats from the master are buffered in a small FIFO.
//   One translation request is issued at a time for the head beat. The head
//   payload is held stable for txs until t_done. A beat that misses
//   translation is dropped, reported on fault_*, and counted.
//
// Ports
//   rx_clk, reset_           clock, synchronous active-low reset
//   in_*, in_valid/in_ready  master beat; in_ready = ~fifo_full
//   out_*                    head payload presented to txs (0 when empty)
//   t_req, t_vaddr           translation request (level) and head vaddr
//   t_done, t_miss           1-cycle translation result pulses
//   tx_busy                  txs holds a beat (its out_valid)
//   fault_valid/id/addr      1-cycle report of a dropped beat
//   fault_cnt                saturating fault counter
module axi_addr_ch_rxs #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rx_clk,
    input  logic                  reset_,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [7:0]            in_len,
    input  logic [2:0]            in_size,
    input  logic [1:0]            in_burst,
    input  logic [2:0]            in_prot,
    input  logic [3:0]            in_cache,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic                  in_lock,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [7:0]            out_len,
    output logic [2:0]            out_size,
    output logic [1:0]            out_burst,
    output logic [2:0]            out_prot,
    output logic [3:0]            out_cache,
    output logic [USER_WIDTH-1:0] out_user,
    output logic                  out_lock,
    output logic                  t_req,
    output logic [ADDR_WIDTH-1:0] t_vaddr,
    input  logic                  t_done,
    input  logic                  t_miss,
    input  logic                  tx_busy,
    output logic                  fault_valid,
    output logic [ID_WIDTH-1:0]   fault_id,
    output logic [ADDR_WIDTH-1:0] fault_addr,
    output logic [CNT_WIDTH-1:0]  fault_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [2:0]            prot;
        logic [3:0]            cache;
        logic [USER_WIDTH-1:0] user;
        logic                  lock;
    } beat_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN
    } state_t;

    beat_t  mem [FIFO_DEPTH];
    beat_t  head;
    beat_t  in_beat;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    state_t state;

    assign in_beat = '{id: in_id, addr: in_addr, len: in_len, size: in_size,
                       burst: in_burst, prot: in_prot, cache: in_cache,
                       user: in_user, lock: in_lock};

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    // t_done wins over t_miss; results outside REQ are ignored.
    assign pop      = (state == S_REQ) && (t_done || t_miss);

    assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign out_id    = head.id;
    assign out_len   = head.len;
    assign out_size  = head.size;
    assign out_burst = head.burst;
    assign out_prot  = head.prot;
    assign out_cache = head.cache;
    assign out_user  = head.user;
    assign out_lock  = head.lock;
    assign t_vaddr   = head.addr;

    always_ff @(posedge rx_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_beat;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!reset_) begin
            state       <= S_IDLE;
            t_req       <= 1'b0;
            fault_valid <= 1'b0;
            fault_id    <= '0;
            fault_addr  <= '0;
            fault_cnt   <= '0;
        end else begin
            fault_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty && !tx_busy) begin
                        state <= S_REQ;
                        t_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (t_done) begin
                        state <= S_DRAIN;
                        t_req <= 1'b0;
                    end else if (t_miss) begin
                        state       <= S_IDLE;
                        t_req       <= 1'b0;
                        fault_valid <= 1'b1;
                        fault_id    <= head.id;
                        fault_addr  <= head.addr;
                        if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Wait for txs to empty so the next t_done cannot be lost.
                    if (!tx_busy) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    t_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_addr_ch_rxs.sv
// tb_axi_addr_ch_rxs
//   Directed bench for axi_addr_ch_rxs. tx_busy, t_done and t_miss are driven
//   by hand to stand in for txs and the translation unit. CNT_WIDTH is
//   reduced to 2 so that counter saturation is reached after a few misses.
module tb_axi_addr_ch_rxs;

    logic        rx_clk;
    logic        reset_;
    logic [7:0]  in_id;
    logic [31:0] in_addr;
    logic [7:0]  in_len;
    logic [2:0]  in_size;
    logic [1:0]  in_burst;
    logic [2:0]  in_prot;
    logic [3:0]  in_cache;
    logic [1:0]  in_user;
    logic        in_lock;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_id;
    logic [7:0]  out_len;
    logic [2:0]  out_size;
    logic [1:0]  out_burst;
    logic [2:0]  out_prot;
    logic [3:0]  out_cache;
    logic [1:0]  out_user;
    logic        out_lock;
    logic        t_req;
    logic [31:0] t_vaddr;
    logic        t_done;
    logic        t_miss;
    logic        tx_busy;
    logic        fault_valid;
    logic [7:0]  fault_id;
    logic [31:0] fault_addr;
    logic [1:0]  fault_cnt;

    int n_cmp = 0;
    int n_err = 0;

    axi_addr_ch_rxs #(
        .ADDR_WIDTH(32),
        .ID_WIDTH  (8),
        .USER_WIDTH(2),
        .FIFO_DEPTH(2),
        .CNT_WIDTH (2)
    ) dut (
        .rx_clk     (rx_clk),
        .reset_     (reset_),
        .in_id      (in_id),
        .in_addr    (in_addr),
        .in_len     (in_len),
        .in_size    (in_size),
        .in_burst   (in_burst),
        .in_prot    (in_prot),
        .in_cache   (in_cache),
        .in_user    (in_user),
        .in_lock    (in_lock),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_id     (out_id),
        .out_len    (out_len),
        .out_size   (out_size),
        .out_burst  (out_burst),
        .out_prot   (out_prot),
        .out_cache  (out_cache),
        .out_user   (out_user),
        .out_lock   (out_lock),
        .t_req      (t_req),
        .t_vaddr    (t_vaddr),
        .t_done     (t_done),
        .t_miss     (t_miss),
        .tx_busy    (tx_busy),
        .fault_valid(fault_valid),
        .fault_id   (fault_id),
        .fault_addr (fault_addr),
        .fault_cnt  (fault_cnt)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; all driving and sampling happens 1 time unit after the edge.
    task automatic step();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic drive_beat(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        in_valid = 1'b1;
        in_id    = id;
        in_addr  = addr;
        in_len   = len;
        in_size  = 3'd2;
        in_burst = 2'd1;
        in_prot  = 3'd0;
        in_cache = 4'd3;
        in_user  = 2'd1;
        in_lock  = 1'b0;
    endtask

    initial begin
        reset_ = 1'b0; in_valid = 1'b0; t_done = 1'b0; t_miss = 1'b0; tx_busy = 1'b0;
        drive_beat(8'h0, 32'h0, 8'h0);
        in_valid = 1'b0;
        step(); step();

        // Reset state
        check("rst_t_req", t_req, 0);
        check("rst_fault_valid", fault_valid, 0);
        check("rst_fault_cnt", fault_cnt, 0);
        check("rst_fault_id", fault_id, 0);
        check("rst_fault_addr", fault_addr, 0);
        check("rst_out_id", out_id, 0);
        check("rst_t_vaddr", t_vaddr, 0);
        check("rst_in_ready", in_ready, 1);
        reset_ = 1'b1;
        step();

        // 1: single beat, t_done two cycles after t_req
        drive_beat(8'h05, 32'h0000_1000, 8'd3);
        step();
        in_valid = 1'b0;
        check("t1_t_req_not_yet", t_req, 0);
        check("t1_head_id", out_id, 8'h05);
        check("t1_head_len", out_len, 3);
        check("t1_head_vaddr", t_vaddr, 32'h0000_1000);
        step();
        check("t1_t_req_up", t_req, 1);
        step(); step();
        check("t1_t_req_held", t_req, 1);
        check("t1_vaddr_held", t_vaddr, 32'h0000_1000);
        t_done = 1'b1;
        check("t1_capture_id", out_id, 8'h05);
        step();
        t_done = 1'b0; tx_busy = 1'b1;
        check("t1_t_req_drop", t_req, 0);
        check("t1_empty_id", out_id, 0);
        step(); step();
        tx_busy = 1'b0;
        step();
        check("t1_idle_t_req", t_req, 0);

        // 2: three beats into a depth-2 FIFO with slow translation
        drive_beat(8'h11, 32'h0000_1100, 8'd0);
        step();
        check("t2_ready_after1", in_ready, 1);
        drive_beat(8'h12, 32'h0000_1200, 8'd1);
        step();
        check("t2_ready_full", in_ready, 0);
        check("t2_req_first", t_req, 1);
        drive_beat(8'h13, 32'h0000_1300, 8'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_ready_stays_low", in_ready, 0);
        end
        check("t2_head1", out_id, 8'h11);
        t_done = 1'b1;
        step();
        t_done = 1'b0;
        check("t2_ready_after_pop", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        check("t2_req2", t_req, 1);
        check("t2_head2", out_id, 8'h12);
        t_done = 1'b1;
        step();
        t_done = 1'b0;
        step(); step();
        check("t2_req3", t_req, 1);
        check("t2_head3", out_id, 8'h13);
        check("t2_head3_len", out_len, 2);
        t_done = 1'b1;
        step();
        t_done = 1'b0;
        step(); step();
        check("t2_drained_req", t_req, 0);
        check("t2_drained_ready", in_ready, 1);

        // 3: translation miss
        drive_beat(8'h09, 32'hDEAD_0000, 8'd0);
        step();
        in_valid = 1'b0;
        step();
        check("t3_req", t_req, 1);
        t_miss = 1'b1;
        step();
        t_miss = 1'b0;
        check("t3_fault_valid", fault_valid, 1);
        check("t3_fault_id", fault_id, 8'h09);
        check("t3_fault_addr", fault_addr, 32'hDEAD_0000);
        check("t3_fault_cnt", fault_cnt, 1);
        check("t3_t_req_drop", t_req, 0);
        drive_beat(8'h0A, 32'h0000_2000, 8'd0);
        step();
        in_valid = 1'b0;
        check("t3_fault_pulse_end", fault_valid, 0);
        step();
        check("t3_next_req", t_req, 1);
        check("t3_next_vaddr", t_vaddr, 32'h0000_2000);
        t_done = 1'b1;
        step();
        t_done = 1'b0;
        check("t3_done_no_fault", fault_valid, 0);
        check("t3_cnt_kept", fault_cnt, 1);
        step();

        // 4: txs back-pressured while a second beat waits
        drive_beat(8'h21, 32'h0000_2100, 8'd0);
        step();
        drive_beat(8'h22, 32'h0000_2200, 8'd0);
        step();
        in_valid = 1'b0;
        check("t4_req1", t_req, 1);
        check("t4_head1", out_id, 8'h21);
        t_done = 1'b1;
        step();
        t_done = 1'b0; tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_req_blocked", t_req, 0);
            check("t4_head2_kept", out_id, 8'h22);
            step();
        end
        tx_busy = 1'b0;
        check("t4_req_still_low", t_req, 0);
        step();
        check("t4_idle_req_low", t_req, 0);
        step();
        check("t4_req2", t_req, 1);
        check("t4_head2", out_id, 8'h22);
        t_done = 1'b1;
        step();
        t_done = 1'b0;
        step();

        // 5: reset while requesting with a full FIFO
        drive_beat(8'h31, 32'h0000_3100, 8'd0);
        step();
        drive_beat(8'h32, 32'h0000_3200, 8'd0);
        step();
        in_valid = 1'b0;
        check("t5_req", t_req, 1);
        check("t5_full", in_ready, 0);
        reset_ = 1'b0;
        step();
        reset_ = 1'b1;
        check("t5_rst_req", t_req, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_head", out_id, 0);
        check("t5_rst_cnt", fault_cnt, 0);
        t_done = 1'b1;
        step();
        t_done = 1'b0; t_miss = 1'b1;
        check("t5_stale_done_req", t_req, 0);
        check("t5_stale_done_ready", in_ready, 1);
        step();
        t_miss = 1'b0;
        check("t5_stale_miss_fv", fault_valid, 0);
        check("t5_stale_miss_cnt", fault_cnt, 0);

        // 6: fault counter saturates at all-ones (CNT_WIDTH=2)
        for (int i = 0; i < 5; i++) begin
            drive_beat(8'h40 + 8'(i), 32'h0000_4000 + 32'(i), 8'd0);
            step();
            in_valid = 1'b0;
            step();
            t_miss = 1'b1;
            step();
            t_miss = 1'b0;
            check("t6_fault_valid", fault_valid, 1);
            check("t6_fault_id", fault_id, 8'h40 + 8'(i));
            check("t6_fault_cnt", fault_cnt, (i < 3) ? i + 1 : 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
